// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// The FSM is the master: it samples the opcode and drives every strobe/select.
interface cpu_control_fsm_if;
  logic [5:0] opcode;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       InstMemRead;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       InstrRegWrite;
  logic [1:0] PCSource;
  logic [2:0] ALUop;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUSrcA;
  logic       RegRead1;
  logic       RegRead2;
  logic       RegWrite;
  logic       ImmExtend;
  logic       RegDst;
  logic       BranchType;

  modport master (
    input  opcode,
    output PCWrite, PCWriteCond, InstMemRead,
    output MemRead, MemWrite, MemtoReg,
    output InstrRegWrite, PCSource, ALUop,
    output ALUSrcB, ALUSrcA, RegRead1,
    output RegRead2, RegWrite, ImmExtend,
    output RegDst, BranchType
  );

  modport slave (
    output opcode,
    input  PCWrite, PCWriteCond, InstMemRead,
    input  MemRead, MemWrite, MemtoReg,
    input  InstrRegWrite, PCSource, ALUop,
    input  ALUSrcB, ALUSrcA, RegRead1,
    input  RegRead2, RegWrite, ImmExtend,
    input  RegDst, BranchType
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multicycle CPU control unit: Moore FSM stepping fetch/decode/exec/mem/wb.
// Strobes depend only on state and the opcode latched at the end of DECODE.
module cpu_control_fsm (
  input  logic              clk,
  input  logic              rst,
  cpu_control_fsm_if.master ctl
);

  typedef enum logic [3:0] {
    INIT, FETCH, DECODE, EXEC_R,
    WB_R, EXEC_I, LI_EXEC, WB_I,
    MEM_ADDR, MEM_READ, MEM_WB,
    MEM_WRITE, BRANCH, JUMP
  } state_t;

  localparam logic [5:0] OP_J   = 6'b000001;
  localparam logic [5:0] OP_LI  = 6'b111001;
  localparam logic [5:0] OP_LWI = 6'b111011;
  localparam logic [5:0] OP_SWI = 6'b111100;
  localparam logic [5:0] OP_ORI = 6'b110100;
  localparam logic [5:0] OP_ANI = 6'b110101;

  state_t     state;
  state_t     stateNext;
  logic [5:0] opReg;

  logic isR, isI, isLi, isMem, isBr, isJ;

  assign isR   = ctl.opcode[5:4] == 2'b01;
  assign isI   = ctl.opcode[5:3] == 3'b110 &&
                 ctl.opcode[2:1] != 2'b00;
  assign isLi  = ctl.opcode == OP_LI;
  assign isMem = ctl.opcode == OP_LWI ||
                 ctl.opcode == OP_SWI;
  assign isBr  = ctl.opcode[5:1] == 5'b10000;
  assign isJ   = ctl.opcode == OP_J;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      opReg <= '0;
    end else begin
      state <= stateNext;
      if (state == DECODE)
        opReg <= ctl.opcode;
    end
  end

  always_comb begin
    stateNext         = state;
    ctl.PCWrite       = 1'b0;
    ctl.PCWriteCond   = 1'b0;
    ctl.InstMemRead   = 1'b0;
    ctl.MemRead       = 1'b0;
    ctl.MemWrite      = 1'b0;
    ctl.MemtoReg      = 1'b0;
    ctl.InstrRegWrite = 1'b0;
    ctl.PCSource      = 2'b00;
    ctl.ALUop         = 3'b000;
    ctl.ALUSrcB       = 2'b00;
    ctl.ALUSrcA       = 2'b00;
    ctl.RegRead1      = 1'b0;
    ctl.RegRead2      = 1'b0;
    ctl.RegWrite      = 1'b0;
    ctl.ImmExtend     = 1'b0;
    ctl.RegDst        = 1'b0;
    ctl.BranchType    = 1'b0;
    unique case (state)
      INIT: stateNext = FETCH;
      FETCH: begin
        ctl.InstMemRead   = 1'b1;
        ctl.InstrRegWrite = 1'b1;
        ctl.PCWrite       = 1'b1;
        ctl.ALUSrcB       = 2'b01;
        ctl.ALUop         = 3'b010;
        stateNext         = DECODE;
      end
      DECODE: begin
        // ALU precomputes the branch target
        ctl.RegRead1  = 1'b1;
        ctl.RegRead2  = 1'b1;
        ctl.ALUSrcB   = 2'b10;
        ctl.ImmExtend = 1'b1;
        ctl.ALUop     = 3'b010;
        unique case (1'b1)
          isR:     stateNext = EXEC_R;
          isI:     stateNext = EXEC_I;
          isLi:    stateNext = LI_EXEC;
          isMem:   stateNext = MEM_ADDR;
          isBr:    stateNext = BRANCH;
          isJ:     stateNext = JUMP;
          default: stateNext = FETCH;
        endcase
      end
      EXEC_R: begin
        ctl.ALUSrcA = 2'b01;
        ctl.ALUop   = opReg[2:0];
        stateNext   = WB_R;
      end
      WB_R: begin
        ctl.RegWrite = 1'b1;
        ctl.RegDst   = 1'b1;
        stateNext    = FETCH;
      end
      EXEC_I: begin
        ctl.ALUSrcA   = 2'b01;
        ctl.ALUSrcB   = 2'b10;
        ctl.ALUop     = opReg[2:0];
        ctl.ImmExtend = !(opReg == OP_ORI ||
                          opReg == OP_ANI);
        stateNext     = WB_I;
      end
      LI_EXEC: begin
        ctl.ALUSrcA   = 2'b10;
        ctl.ALUSrcB   = 2'b10;
        ctl.ALUop     = 3'b010;
        ctl.ImmExtend = 1'b1;
        stateNext     = WB_I;
      end
      WB_I: begin
        ctl.RegWrite = 1'b1;
        stateNext    = FETCH;
      end
      MEM_ADDR: begin
        ctl.ALUSrcA = 2'b10;
        ctl.ALUSrcB = 2'b10;
        ctl.ALUop   = 3'b010;
        stateNext   = (opReg == OP_LWI) ?
                      MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        ctl.MemRead = 1'b1;
        stateNext   = MEM_WB;
      end
      MEM_WB: begin
        ctl.RegWrite = 1'b1;
        ctl.MemtoReg = 1'b1;
        stateNext    = FETCH;
      end
      MEM_WRITE: begin
        ctl.MemWrite = 1'b1;
        stateNext    = FETCH;
      end
      BRANCH: begin
        ctl.ALUSrcA     = 2'b01;
        ctl.ALUop       = 3'b011;
        ctl.PCWriteCond = 1'b1;
        ctl.PCSource    = 2'b01;
        ctl.BranchType  = opReg[0];
        stateNext       = FETCH;
      end
      JUMP: begin
        ctl.PCWrite  = 1'b1;
        ctl.PCSource = 2'b10;
        stateNext    = FETCH;
      end
      default: stateNext = INIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: per-opcode state walk tables
// plus reset-at-start and reset-mid-instruction sequences.
module tb_cpu_control_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  cpu_control_fsm_if bus ();

  cpu_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus.master)
  );

  always #5 clk = ~clk;

  typedef logic [21:0] cw_t;

  typedef struct packed {
    logic [5:0]      op;
    logic [2:0]      n;
    logic [4:0][21:0] exp;
  } vec_t;

  function automatic cw_t cw(
    logic pcw, pcwc, imr, mr, mw, m2r, irw,
    logic [1:0] ps, logic [2:0] alu,
    logic [1:0] sb, logic [1:0] sa,
    logic rr1, rr2, rw, ie, rd, bt);
    return {pcw, pcwc, imr, mr, mw, m2r, irw,
            ps, alu, sb, sa,
            rr1, rr2, rw, ie, rd, bt};
  endfunction

  function automatic cw_t actual();
    return {bus.PCWrite, bus.PCWriteCond,
            bus.InstMemRead, bus.MemRead,
            bus.MemWrite, bus.MemtoReg,
            bus.InstrRegWrite, bus.PCSource,
            bus.ALUop, bus.ALUSrcB, bus.ALUSrcA,
            bus.RegRead1, bus.RegRead2,
            bus.RegWrite, bus.ImmExtend,
            bus.RegDst, bus.BranchType};
  endfunction

  cw_t fetchW, decodeW, wbrW, wbiW, liW;
  cw_t maddrW, mrdW, mwbW, mwrW, jmpW;

  function automatic cw_t execR(logic [2:0] a);
    return cw(0,0,0,0,0,0,0, 2'b00, a,
              2'b00, 2'b01, 0,0,0,0,0,0);
  endfunction

  function automatic cw_t execI(logic [2:0] a,
                                logic ie);
    return cw(0,0,0,0,0,0,0, 2'b00, a,
              2'b10, 2'b01, 0,0,0,ie,0,0);
  endfunction

  function automatic cw_t branch(logic bt);
    return cw(0,1,0,0,0,0,0, 2'b01, 3'b011,
              2'b00, 2'b01, 0,0,0,0,0,bt);
  endfunction

  function automatic vec_t mkv(logic [5:0] op,
    logic [2:0] n, cw_t w2, cw_t w3, cw_t w4);
    vec_t v;
    v.op     = op;
    v.n      = n;
    v.exp[0] = fetchW;
    v.exp[1] = decodeW;
    v.exp[2] = w2;
    v.exp[3] = w3;
    v.exp[4] = w4;
    return v;
  endfunction

  task automatic check(string name, cw_t exp);
    cw_t act;
    act = actual();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[16];

  initial begin
    fetchW  = cw(1,0,1,0,0,0,1, 2'b00, 3'b010,
                 2'b01, 2'b00, 0,0,0,0,0,0);
    decodeW = cw(0,0,0,0,0,0,0, 2'b00, 3'b010,
                 2'b10, 2'b00, 1,1,0,1,0,0);
    wbrW    = cw(0,0,0,0,0,0,0, 2'b00, 3'b000,
                 2'b00, 2'b00, 0,0,1,0,1,0);
    wbiW    = cw(0,0,0,0,0,0,0, 2'b00, 3'b000,
                 2'b00, 2'b00, 0,0,1,0,0,0);
    liW     = cw(0,0,0,0,0,0,0, 2'b00, 3'b010,
                 2'b10, 2'b10, 0,0,0,1,0,0);
    maddrW  = cw(0,0,0,0,0,0,0, 2'b00, 3'b010,
                 2'b10, 2'b10, 0,0,0,0,0,0);
    mrdW    = cw(0,0,0,1,0,0,0, 2'b00, 3'b000,
                 2'b00, 2'b00, 0,0,0,0,0,0);
    mwbW    = cw(0,0,0,0,0,1,0, 2'b00, 3'b000,
                 2'b00, 2'b00, 0,0,1,0,0,0);
    mwrW    = cw(0,0,0,0,1,0,0, 2'b00, 3'b000,
                 2'b00, 2'b00, 0,0,0,0,0,0);
    jmpW    = cw(1,0,0,0,0,0,0, 2'b10, 3'b000,
                 2'b00, 2'b00, 0,0,0,0,0,0);

    vecs[0]  = mkv(6'b000000, 2, '0, '0, '0);
    vecs[1]  = mkv(6'b111111, 2, '0, '0, '0);
    vecs[2]  = mkv(6'b010010, 4, execR(3'b010), wbrW, '0);
    vecs[3]  = mkv(6'b010011, 4, execR(3'b011), wbrW, '0);
    vecs[4]  = mkv(6'b010000, 4, execR(3'b000), wbrW, '0);
    vecs[5]  = mkv(6'b010111, 4, execR(3'b111), wbrW, '0);
    vecs[6]  = mkv(6'b110100, 4, execI(3'b100, 0), wbiW, '0);
    vecs[7]  = mkv(6'b110101, 4, execI(3'b101, 0), wbiW, '0);
    vecs[8]  = mkv(6'b110010, 4, execI(3'b010, 1), wbiW, '0);
    vecs[9]  = mkv(6'b110111, 4, execI(3'b111, 1), wbiW, '0);
    vecs[10] = mkv(6'b111001, 4, liW, wbiW, '0);
    vecs[11] = mkv(6'b111011, 5, maddrW, mrdW, mwbW);
    vecs[12] = mkv(6'b111100, 4, maddrW, mwrW, '0);
    vecs[13] = mkv(6'b100000, 3, branch(0), '0, '0);
    vecs[14] = mkv(6'b100001, 3, branch(1), '0, '0);
    vecs[15] = mkv(6'b000001, 3, jmpW, '0, '0);

    bus.opcode = 6'b000000;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_hold", '0);
    end
    rst = 1'b1;
    #1;
    check("init_after_release", '0);
    step();
    check("first_fetch", fetchW);

    for (int v = 0; v < 16; v++) begin
      check($sformatf("op%b_s0", vecs[v].op),
            vecs[v].exp[0]);
      bus.opcode = vecs[v].op;
      for (int k = 1; k < 5; k++) begin
        if (k < int'(vecs[v].n)) begin
          step();
          check($sformatf("op%b_s%0d",
                vecs[v].op, k), vecs[v].exp[k]);
        end
      end
      step();
    end
    check("final_fetch", fetchW);

    bus.opcode = 6'b010010;
    step();
    check("abort_decode", decodeW);
    step();
    check("abort_exec_r", execR(3'b010));
    #2;
    rst = 1'b0;
    #1;
    check("abort_async", '0);
    step();
    check("abort_hold", '0);
    rst = 1'b1;
    bus.opcode = 6'b000000;
    #1;
    check("abort_init", '0);
    step();
    check("abort_refetch", fetchW);
    step();
    check("abort_redecode", decodeW);
    step();
    check("abort_noop_back", fetchW);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
